// File: rtl/div_seq_radix2_pkg.sv
// Shared constants and state encoding for the sequential radix-2 divider.
package div_seq_radix2_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic [4:0] DIV_ITER_LAST = 5'd31;

  // Divide by zero: the quotient is all ones and the remainder is the dividend.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate. It takes absolute values of the
// operands and applies the sign to the quotient and remainder.
module div_sign_fix
  import div_seq_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/div_seq_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, with result = {rem, quo}.
// Build option DIV_EARLY_OUT_EN: an operation with |a| < |b| skips the iteration phase.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for start; latches the operands and the sign flags
// DIV_CALC | one shift/subtract iteration per cycle, 32 cycles in all
// DIV_DONE | result register is valid; ready pulse is high
module div_seq_radix2
  import div_seq_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             q_neg_q, r_neg_q, dz_q;
  logic [4:0]       cnt_q;

  logic             a_neg, b_neg, early;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_nx, quo_nx, rem_fix, quo_fix;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.val(a), .neg(a_neg), .res(abs_a));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.val(b), .neg(b_neg), .res(abs_b));

`ifdef DIV_EARLY_OUT_EN
  assign early = (b != '0) && (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // The restore path only runs when shifted < divisor, so bit WIDTH is zero there.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    if (shifted >= {1'b0, dvs_q}) begin
      rem_nx = shifted[WIDTH-1:0] - dvs_q;
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Remainder fix on |a| restores the original a, which is also the divide-by-zero result.
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.val(quo_nx), .neg(q_neg_q & ~dz_q), .res(quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.val(rem_nx), .neg(r_neg_q), .res(rem_fix));

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        stall = rst & start & ~annul;
        if (start && !annul) state_d = early ? DIV_DONE : DIV_CALC;
      end
      DIV_CALC: begin
        stall = ~annul;
        if (annul) state_d = DIV_IDLE;
        else if (cnt_q == DIV_ITER_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        ready   = ~annul;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DIV_IDLE: begin
          if (start && !annul) begin
            rem_q   <= '0;
            quo_q   <= abs_a;
            dvs_q   <= abs_b;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= (b == '0);
            cnt_q   <= '0;
            if (early) result <= {a, {WIDTH{1'b0}}};
          end
        end
        DIV_CALC: begin
          if (!annul) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == DIV_ITER_LAST)
              result <= {rem_fix, dz_q ? DIV_ZERO_QUO : quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_seq_radix2.md
Name: div_seq_radix2

Overview:
- Multi-cycle radix-2 restoring divider serving DIV/DIVU for the execute-stage ALU.
- It is the responder end of the ALU's start/ready/stall divide handshake: the ALU holds start while ready is low, and this block raises stall until the quotient and remainder are available.
- The 64-bit result feeds the HI/LO write path as {remainder, quotient}.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; asynchronous, active-low.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  32  dividend; sampled with start.
- b  in  32  divisor; sampled with start.
- start  in  1  level request from ALU; held high until ready is seen.
- annul  in  1  abort the current operation (exception flush).
- result  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready  out  1  one-cycle pulse; result is valid.
- stall  out  1  pipeline freeze request.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, result=0, ready=0, stall=0, counter=0. Reset mid-operation discards all work; no ready pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - stall = start & ~annul, combinational, so the pipeline freezes in the same cycle start appears.
  - On start & ~annul: latch |a| and |b| (absolute values only when signed_div=1), latch the quotient sign (a[31]^b[31]) and remainder sign (a[31]) gated by signed_div, set counter=0, go to CALC.
- CALC:
  - One iteration per cycle: shift {rem, quo} left 1; trial = rem - divisor (33-bit); if trial is non-negative, rem = trial and quo[0] = 1.
  - counter increments each cycle; after the 32nd iteration (counter=31) go to DONE. stall=1 throughout.
- DONE:
  - Apply sign fixes: negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Register result, ready=1 for exactly this cycle, stall=0, then return to IDLE.
- Latency: start seen in cycle 0, ready in cycle 33 (34 cycles total). result holds its value until the next DONE.
- start is ignored in DONE. A start still high in the following IDLE cycle begins a new operation.
- annul in any state: go to IDLE next edge, no ready. stall is forced to 0 in the same cycle annul is high. result is unchanged.
- Divide by zero (b=0, either mode): quotient = 0xFFFFFFFF, remainder = a; sign fixes are skipped. Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out of the 32-bit wrap of the negation.
- Changes to a, b or signed_div after the start sample have no effect.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if b != 0 and |a| < |b| (includes a=0), skip CALC and go directly to DONE. Result = {a, 0}, i.e. remainder = original signed a, quotient = 0. ready arrives in cycle 1.
- Undefined: all non-annulled operations take the fixed 34-cycle latency.

Decomposition:
- Shared package holds:
  - DIV_WIDTH=32.
  - State encoding DIV_IDLE=2'b00, DIV_CALC=2'b01, DIV_DONE=2'b10.
  - DIV_ITER_LAST=5'd31.
  - The divide-by-zero result constants.
- One natural sub-module: div_sign_fix, the combinational absolute-value and conditional-negate helper. It is used for operand pre-processing and result post-processing.
- The state machine, counter and shift datapath stay in div_seq_radix2.

Test Plan:
- DIVU 100/7, start held until ready -> ready at cycle 33, result = {32'd2, 32'd14}; stall high cycles 0-32, low at 33.
- DIV -7/2 (0xFFFFFFF9 / 0x2) -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0. DIVU 5/0 -> quotient = 0xFFFFFFFF, remainder = 5.
- annul at cycle 10 of a DIVU 1000/3:
  - stall = 0 in cycle 10, state IDLE at cycle 11, no ready, result keeps its previous value.
  - A following start of 9/3 -> result {0, 3} at 33 cycles after its start.
- rst low at cycle 15 mid-operation -> ready and stall = 0 immediately, result = 0. After release, a fresh 20/6 gives {2, 3}.
- With DIV_EARLY_OUT_EN, DIVU 3/10 -> ready at cycle 1, result {3, 0}; without the macro -> ready at cycle 33, same result.
